scalar_rf_wb_arbiter: RTL
=========================

# scalar_rf_wb_arbiter

Write-back controller for the 32-entry scalar register file. It shares the file's single write port (RD/WD/WES) among NREQ write-back requesters using a round-robin scheme. It also keeps a per-register busy scoreboard that stalls issue on RAW/WAW hazards. It sits between the execution units (ALU, load unit, vector-reduce unit) and the scalar register file write port.

## Interface
- WIDTH, 16, data width; must match the register file
- NREQ, 3, number of write-back requesters (2..8); index 0 = ALU, 1 = load, 2 = vector-reduce
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- req_valid  input  NREQ  requester i has a result
- req_rd  input  5*NREQ  destination register of requester i; slice [5i+4:5i]
- req_wd  input  WIDTH*NREQ  result data of requester i; slice [WIDTH*i+WIDTH-1:WIDTH*i]
- req_ready  output  NREQ  one-hot grant; the transfer occurs when req_valid[i] & req_ready[i]
- rf_rd  output  5  register file RD
- rf_wd  output  WIDTH  register file WD
- rf_wes  output  1  register file WES
- iss_valid  input  1  decoder presents an instruction
- iss_rs1, iss_rs2, iss_rs3  input  5 each  source registers
- iss_rd  input  5  destination register
- iss_wr  input  1  instruction writes iss_rd
- iss_stall  output  1  instruction must not issue this cycle
- busy  output  32  scoreboard state, for debug

## Operation
- Arbitration:
  - Round-robin pointer ptr (0..NREQ-1).
  - Grant goes to the first i with req_valid[i] = 1, searching ptr, ptr+1, … and wrapping modulo NREQ.
  - req_ready is combinational from req_valid and ptr. It is all-zero when no request is valid.
  - Requesters hold valid, rd and wd stable until granted.
- Pointer update: on a granted cycle, ptr ← granted index + 1, wrapping NREQ-1 → 0. With no grant, ptr holds.
- Write port:
  - On a grant, the next cycle presents rf_wes = 1, rf_rd = granted rd, rf_wd = granted wd, all registered.
  - With no grant, rf_wes = 0 and rf_rd/rf_wd hold their last values.
- Scoreboard: busy is 32 flops.
  - iss_stall = iss_valid & (busy[rs1] | busy[rs2] | busy[rs3] | (iss_wr & busy[iss_rd])). This is combinational.
  - An accepted issue is iss_valid & ~iss_stall & iss_wr. It sets busy[iss_rd] at the clock edge.
  - A granted write-back clears busy[granted rd] at the same edge as the grant, not the rf_wes cycle.
  - Set and clear of the same register in the same cycle: set wins.
  - Write-back to a register that is not busy is legal. The clear is a no-op.
- No forwarding. A source becomes issuable the cycle after its grant edge, which is when rf_wes is high. The register file read is combinational, so the issuing instruction reads the old value at that point. The team rule is therefore that decode samples operands one cycle after iss_stall falls.

## Timing
- Reset values: ptr = 0, busy = 0, rf_wes = 0, rf_rd = 0, rf_wd = 0. req_ready and iss_stall follow their combinational rules from reset state.
- Reset mid-operation: pending requests are dropped, the scoreboard is cleared, and no rf_wes is generated in the cycle after rst deasserts.
- Latency: grant edge to rf_wes is 1 cycle. Grant edge to busy clear is 0 cycles (same edge).
- Throughput: one write-back per cycle. With all NREQ requesters continuously valid, each is granted once every NREQ cycles.
- Starvation bound: a valid requester is granted within NREQ cycles.

## Configuration
- SCALAR_WB_R0_ZERO_EN defined:
  - A granted write-back with rd = 0 is consumed (ready asserted, ptr advances) but produces rf_wes = 0.
  - busy[0] is never set.
  - Register 0 reads as an architectural constant.
- SCALAR_WB_R0_ZERO_EN undefined: register 0 is ordinary. Writes and scoreboard tracking apply to it.

## Structure
- Package scalar_rf_pkg holds:
  - REG_ADDR_W = 5 and NUM_REGS = 32.
  - Requester index enum: WB_ALU = 0, WB_LOAD = 1, WB_VRED = 2.
  - typedef reg_addr_t.
- One sub-module, rr_arbiter: parameter N; inputs req[N-1:0] and ptr; outputs one-hot gnt and encoded idx. It is purely combinational.
- The top-level block holds ptr, the write-port registers and the scoreboard.

## Test plan
- Reset with all requests valid → ready = 0 and rf_wes = 0 during rst. First grant after release goes to requester 0.
- All three requesters valid continuously with rd = 1, 2, 3 → grants 0, 1, 2, 0, … Each rf_wes cycle shows the matching rd and wd one cycle after its grant.
- Issue rd = 5 (iss_wr = 1), then issue rs1 = 5 → iss_stall = 1 until requester 1 is granted with rd = 5. iss_stall = 0 from the next cycle.
- The same cycle holds an accepted issue with rd = 7 and a granted write-back with rd = 7 → busy[7] = 1 afterwards.
- Requester 2 alone valid while ptr = 0 → granted immediately and ptr becomes 0 (wrap from 2).
- Write-back with rd = 0, wd = 0xBEEF → rf_wes = 0 with SCALAR_WB_R0_ZERO_EN defined; rf_wes = 1 and rf_wd = 0xBEEF without it.

Source files
------------

// File: rtl/scalar_rf_pkg.sv
// Shared constants and types for the scalar register file write-back path.
package scalar_rf_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 32;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_LOAD = 2'd1,
        WB_VRED = 2'd2
    } wb_req_e;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    function automatic logic [NUM_REGS-1:0] reg_onehot(input reg_addr_t a);
        logic [NUM_REGS-1:0] v;
        v    = '0;
        v[a] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first valid request at or after ptr, wrapping modulo N.
module rr_arbiter #(
    parameter int unsigned N  = 3,
    parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    logic          found;
    logic [IW:0]   sum;
    logic [IW-1:0] cand;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        sum   = '0;
        cand  = '0;
        for (int k = 0; k < int'(N); k++) begin
            sum = {1'b0, ptr} + (IW + 1)'(k);
            if (sum >= (IW + 1)'(N)) begin
                sum = sum - (IW + 1)'(N);
            end
            cand = sum[IW-1:0];
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/scalar_rf_wb_arbiter.sv
// Shares the scalar RF write port among NREQ requesters and tracks per-register busy bits.
// Define SCALAR_WB_R0_ZERO_EN to make register 0 a hardwired constant (writes dropped, never busy).
module scalar_rf_wb_arbiter
    import scalar_rf_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned NREQ  = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NREQ-1:0]              req_valid,
    input  logic [REG_ADDR_W*NREQ-1:0]   req_rd,
    input  logic [WIDTH*NREQ-1:0]        req_wd,
    output logic [NREQ-1:0]              req_ready,
    output logic [REG_ADDR_W-1:0]        rf_rd,
    output logic [WIDTH-1:0]             rf_wd,
    output logic                         rf_wes,
    input  logic                         iss_valid,
    input  logic [REG_ADDR_W-1:0]        iss_rs1,
    input  logic [REG_ADDR_W-1:0]        iss_rs2,
    input  logic [REG_ADDR_W-1:0]        iss_rs3,
    input  logic [REG_ADDR_W-1:0]        iss_rd,
    input  logic                         iss_wr,
    output logic                         iss_stall,
    output logic [NUM_REGS-1:0]          busy
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]       ptr_q, ptr_d;
    logic [NREQ-1:0]     gnt;
    logic [PW-1:0]       gnt_idx;
    logic                any_gnt;
    reg_addr_t           gnt_rd;
    logic [WIDTH-1:0]    gnt_wd;
    logic                wb_en;
    logic                iss_accept;
    logic [NUM_REGS-1:0] busy_d;

    rr_arbiter #(
        .N  (NREQ),
        .IW (PW)
    ) u_rr_arbiter (
        .req (req_valid),
        .ptr (ptr_q),
        .gnt (gnt),
        .idx (gnt_idx)
    );

    // No transfer is accepted while reset is held, so pending requests are dropped.
    assign req_ready = rst ? '0 : gnt;
    assign any_gnt   = |req_ready;

    always_comb begin
        gnt_rd = '0;
        gnt_wd = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (gnt[i]) begin
                gnt_rd = req_rd[i*REG_ADDR_W +: REG_ADDR_W];
                gnt_wd = req_wd[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (any_gnt) begin
            ptr_d = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + PW'(1);
        end
    end

`ifdef SCALAR_WB_R0_ZERO_EN
    assign wb_en = any_gnt && (gnt_rd != '0);
`else
    assign wb_en = any_gnt;
`endif

    assign iss_stall  = iss_valid & (busy[iss_rs1] | busy[iss_rs2] | busy[iss_rs3] |
                                     (iss_wr & busy[iss_rd]));
    assign iss_accept = iss_valid & ~iss_stall & iss_wr;

    // Clear applied before set so an issue and a write-back to the same register leave it busy.
    always_comb begin
        busy_d = busy;
        if (any_gnt) begin
            busy_d = busy_d & ~reg_onehot(gnt_rd);
        end
        if (iss_accept) begin
            busy_d = busy_d | reg_onehot(iss_rd);
        end
`ifdef SCALAR_WB_R0_ZERO_EN
        busy_d[0] = 1'b0;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q  <= '0;
            busy   <= '0;
            rf_wes <= 1'b0;
            rf_rd  <= '0;
            rf_wd  <= '0;
        end else begin
            ptr_q  <= ptr_d;
            busy   <= busy_d;
            rf_wes <= wb_en;
            if (wb_en) begin
                rf_rd <= gnt_rd;
                rf_wd <= gnt_wd;
            end
        end
    end

endmodule
